alu_arbiter: RTL and testbench

Shares one instance of the team's existing combinational ALU (module ALU; operands a/b, op m, result y, flags zf/cf/of) between two independent requesters. Each requester has a valid/ready request channel and a valid/ready response channel. Requests are granted round-robin. Operands are latched, evaluated through the ALU and the registered result and flags are returned. This block is the ALU's access controller in the lab datapath, for example shared by a sequence generator and a debug/test port.

---
 rtl/alu_arbiter.sv | 168 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared combinational ALU.
// Latency: response valid in the cycle after the single EXEC cycle (3 cycles per op best case).
// Backpressure: req_ready only in IDLE; result held in RESP until rsp_valid&rsp_ready.

module ALU #(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 3
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [ALUOP_W-1:0] m,
    output logic [WIDTH-1:0]   y,
    output logic               zf,
    output logic               cf,
    output logic               of
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        y   = '0;
        cf  = 1'b0;
        of  = 1'b0;
        case (m)
            ALUOP_W'(0): begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[WIDTH-1:0];
                cf  = sum[WIDTH];
                of  = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ALUOP_W'(1): begin
                // Top bit of the widened difference is the borrow out.
                sum = {1'b0, a} - {1'b0, b};
                y   = sum[WIDTH-1:0];
                cf  = sum[WIDTH];
                of  = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            ALUOP_W'(2): y = a & b;
            ALUOP_W'(3): y = a | b;
            ALUOP_W'(4): y = a ^ b;
            ALUOP_W'(5): y = ~(a | b);
            ALUOP_W'(6): y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALUOP_W'(7): y = b;
            default:     y = '0;
        endcase
        zf = (y == '0);
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [WIDTH-1:0]   req_a0,
    input  logic [WIDTH-1:0]   req_a1,
    input  logic [WIDTH-1:0]   req_b0,
    input  logic [WIDTH-1:0]   req_b1,
    input  logic [ALUOP_W-1:0] req_m0,
    input  logic [ALUOP_W-1:0] req_m1,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_y,
    output logic               rsp_zf,
    output logic               rsp_cf,
    output logic               rsp_of,
    output logic               busy,
    output logic               grant_id
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e             state_q;
    logic               prio_q;
    logic               grant_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [ALUOP_W-1:0] m_q;
    logic [1:0]         rsp_vld_q;
    logic [WIDTH-1:0]   rsp_y_q;
    logic               zf_q, cf_q, of_q;

    logic               cand;
    logic               accept;
    logic               rsp_fire;
    logic [WIDTH-1:0]   a_d, b_d;
    logic [ALUOP_W-1:0] m_d;
    logic [WIDTH-1:0]   alu_y;
    logic               alu_zf, alu_cf, alu_of;

    // With both requesters pending the pointer decides; otherwise the lone requester wins.
    always_comb begin
        cand = 1'b0;
        if (req_valid == 2'b11) cand = prio_q;
        else                    cand = req_valid[1];
    end

    assign req_ready = (state_q == IDLE && req_valid[cand]) ? (2'b01 << cand) : 2'b00;
    assign accept    = |(req_valid & req_ready);
    assign rsp_fire  = |(rsp_vld_q & rsp_ready);

    assign a_d = cand ? req_a1 : req_a0;
    assign b_d = cand ? req_b1 : req_b0;
    assign m_d = cand ? req_m1 : req_m0;

    ALU #(.WIDTH(WIDTH), .ALUOP_W(ALUOP_W)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .m  (m_q),
        .y  (alu_y),
        .zf (alu_zf),
        .cf (alu_cf),
        .of (alu_of)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            grant_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            rsp_vld_q <= 2'b00;
            rsp_y_q   <= '0;
            zf_q      <= 1'b0;
            cf_q      <= 1'b0;
            of_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        m_q     <= m_d;
                        grant_q <= cand;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_q   <= alu_y;
                    zf_q      <= alu_zf;
                    cf_q      <= alu_cf;
                    of_q      <= alu_of;
                    rsp_vld_q <= 2'b01 << grant_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    if (rsp_fire) begin
                        rsp_vld_q <= 2'b00;
                        prio_q    <= ~grant_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zf    = zf_q;
    assign rsp_cf    = cf_q;
    assign rsp_of    = of_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter at WIDTH=8: arithmetic results, arbitration order,
// response stalls, mid-operation reset and request withdrawal.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
    logic [7:0] req_a0, req_a1, req_b0, req_b1, rsp_y;
    logic [2:0] req_m0, req_m1;
    logic       rsp_zf, rsp_cf, rsp_of, busy, grant_id;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(8), .ALUOP_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .req_m0    (req_m0),
        .req_m1    (req_m1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_zf    (rsp_zf),
        .rsp_cf    (rsp_cf),
        .rsp_of    (rsp_of),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] m);
        if (id) begin req_a1 = a; req_b1 = b; req_m1 = m; end
        else    begin req_a0 = a; req_b0 = b; req_m0 = m; end
    endtask

    // Single request from one requester, rsp_ready assumed high; starts and ends at a negedge in IDLE.
    task automatic txn(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] m,
                       input logic [7:0] ey, input logic ezf, input logic ecf, input logic eof);
        logic [1:0] oh;
        oh = id ? 2'b10 : 2'b01;
        set_req(id, a, b, m);
        req_valid[id] = 1'b1;
        #1;
        for (int k = 0; k < 20 && !req_ready[id]; k++) begin
            @(negedge clk); #1;
        end
        check_eq("txn_req_ready", req_ready, oh);
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        check_eq("exec_rsp_valid", rsp_valid, 2'b00);
        check_eq("exec_busy", busy, 1'b1);
        check_eq("exec_grant_id", grant_id, id);
        @(negedge clk);
        check_eq("resp_valid", rsp_valid, oh);
        check_eq("resp_y", rsp_y, ey);
        check_eq("resp_flags", {rsp_zf, rsp_cf, rsp_of}, {ezf, ecf, eof});
        @(negedge clk);
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_rsp_valid", rsp_valid, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_m0 = '0; req_m1 = '0;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rsp_valid", rsp_valid, 2'b00);
        check_eq("rst_req_ready", req_ready, 2'b00);
        check_eq("rst_rsp_y", rsp_y, 8'h00);
        check_eq("rst_flags", {rsp_zf, rsp_cf, rsp_of}, 3'b000);
        check_eq("rst_grant_id", grant_id, 1'b0);
        rst_n = 1'b1;
        rsp_ready = 2'b11;

        // Basic arithmetic and flags
        txn(1'b0, 8'd3,   8'd4, 3'd0, 8'h07, 1'b0, 1'b0, 1'b0);
        txn(1'b1, 8'd0,   8'd1, 3'd1, 8'hFF, 1'b0, 1'b1, 1'b0);
        txn(1'b1, 8'd127, 8'd1, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1);
        txn(1'b1, 8'd5,   8'd5, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0);

        // Both requesters held: alternating grants from reset
        do_reset();
        set_req(1'b0, 8'd1,  8'd2, 3'd0);
        set_req(1'b1, 8'd10, 8'd3, 3'd1);
        req_valid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            #1;
            check_eq("rr_req_ready", req_ready, (t % 2) ? 2'b10 : 2'b01);
            @(posedge clk);
            @(negedge clk);
            check_eq("rr_exec_ready", req_ready, 2'b00);
            check_eq("rr_grant_id", grant_id, t % 2);
            @(negedge clk);
            check_eq("rr_rsp_valid", rsp_valid, (t % 2) ? 2'b10 : 2'b01);
            check_eq("rr_rsp_y", rsp_y, (t % 2) ? 8'd7 : 8'd3);
            @(negedge clk);
        end

        // Response stall with a pending competitor
        rsp_ready = 2'b00;
        set_req(1'b0, 8'd200, 8'd100, 3'd0);
        #1;
        check_eq("stall_req_ready", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_rsp_valid", rsp_valid, 2'b01);
            check_eq("stall_rsp_y", rsp_y, 8'h2C);
            check_eq("stall_flags", {rsp_zf, rsp_cf, rsp_of}, 3'b010);
            check_eq("stall_req_ready", req_ready, 2'b00);
            check_eq("stall_busy", busy, 1'b1);
            @(negedge clk);
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        check_eq("stall_other_ready_ignored", rsp_valid, 2'b01);
        rsp_ready = 2'b11;
        @(negedge clk);
        #1;
        check_eq("post_stall_req_ready", req_ready, 2'b10);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("post_stall_rsp_valid", rsp_valid, 2'b10);
        check_eq("post_stall_rsp_y", rsp_y, 8'd7);
        @(negedge clk);

        // Reset during EXEC after the pointer has moved to requester 1
        txn(1'b0, 8'd9, 8'd4, 3'd1, 8'd5, 1'b0, 1'b0, 1'b0);
        set_req(1'b0, 8'd1,  8'd2, 3'd0);
        set_req(1'b1, 8'd10, 8'd3, 3'd1);
        req_valid = 2'b11;
        #1;
        check_eq("pre_rst_req_ready", req_ready, 2'b10);
        @(posedge clk);
        @(negedge clk);
        check_eq("pre_rst_busy", busy, 1'b1);
        check_eq("pre_rst_grant_id", grant_id, 1'b1);
        req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_rsp_valid", rsp_valid, 2'b00);
        check_eq("midrst_req_ready", req_ready, 2'b00);
        check_eq("midrst_rsp_y", rsp_y, 8'h00);
        check_eq("midrst_grant_id", grant_id, 1'b0);
        @(negedge clk);
        check_eq("midrst_no_rsp", rsp_valid, 2'b00);
        rst_n = 1'b1;
        req_valid = 2'b11;
        #1;
        check_eq("postrst_req_ready", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check_eq("postrst_rsp_valid", rsp_valid, 2'b01);
        check_eq("postrst_rsp_y", rsp_y, 8'd3);
        @(negedge clk);

        // Requester 1 withdraws; requester 0 runs back-to-back
        do_reset();
        set_req(1'b0, 8'd1, 8'd1, 3'd0);
        req_valid = 2'b11;
        for (int c = 0; c < 9; c++) begin
            #1;
            check_eq("b2b_req_ready", req_ready, (c % 3 == 0) ? 2'b01 : 2'b00);
            check_eq("b2b_rsp_valid", rsp_valid, (c % 3 == 2) ? 2'b01 : 2'b00);
            if (c % 3 == 2) check_eq("b2b_rsp_y", rsp_y, 8'd2);
            @(posedge clk);
            @(negedge clk);
            if (c == 0) req_valid[1] = 1'b0;
        end
        req_valid = 2'b00;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
